// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl: BIST sequencer that walks basic_gates through all four (A,B)
// inputs, checks the outputs against the golden truth table and reports diagnostics.
module gate_selftest_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       gate_a_o,
    output logic       gate_b_o,
    input  logic [7:0] gate_out_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_mask_o,
    output logic [7:0] fail_obs_o
);
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
    // Golden gate_out for v = 3..0, packed MSB-first
    localparam logic [31:0] GOLDEN = 32'h835A_56BC;
    state_t           state_q;
    logic [1:0]       v_q;
    logic [CNT_W-1:0] cnt_q;
    logic             gate_a_q, gate_b_q, busy_q, done_q, pass_q;
    logic [3:0]       fail_mask_q, fail_mask_d;
    logic [7:0]       fail_obs_q;
    logic             mismatch;
    assign mismatch    = gate_out_i != GOLDEN[{v_q, 3'b000} +: 8];
    assign fail_mask_d = fail_mask_q | (mismatch ? (4'b0001 << v_q) : 4'b0000);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            v_q         <= 2'd0;
            cnt_q       <= '0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'h0;
            fail_obs_q  <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != IDLE) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                gate_a_q <= 1'b0;
                gate_b_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        fail_mask_q <= 4'h0;
                        fail_obs_q  <= 8'h00;
                        pass_q      <= 1'b0;
                        v_q         <= 2'd0;
                        busy_q      <= 1'b1;
                        state_q     <= APPLY;
                    end
                    APPLY: begin
                        {gate_a_q, gate_b_q} <= v_q;
                        cnt_q   <= CNT_W'(SETTLE_CYCLES);
                        state_q <= SETTLE;
                    end
                    SETTLE: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_q <= CHECK;
                    end
                    CHECK: begin
                        if (mismatch) begin
                            fail_mask_q <= fail_mask_d;
                            fail_obs_q  <= gate_out_i;
                        end
                        if (v_q == 2'd3) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            pass_q   <= fail_mask_d == 4'h0;
                            gate_a_q <= 1'b0;
                            gate_b_q <= 1'b0;
                        end else begin
                            v_q     <= v_q + 2'd1;
                            state_q <= APPLY;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign gate_a_o    = gate_a_q;
    assign gate_b_o    = gate_b_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_mask_o = fail_mask_q;
    assign fail_obs_o  = fail_obs_q;
endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// tb_gate_selftest_ctrl: directed bench with a behavioural basic_gates model and
// selectable output faults.
module tb_gate_selftest_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       gate_a, gate_b, busy, done, pass;
    logic [7:0] gate_out, good;
    logic [3:0] fail_mask;
    logic [7:0] fail_obs;
    int         mode = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    always #5 clk = ~clk;
    assign good = {~(gate_a ^ gate_b), gate_a ^ gate_b, ~(gate_a | gate_b), ~(gate_a & gate_b),
                   ~gate_b, ~gate_a, gate_a | gate_b, gate_a & gate_b};
    // mode 1: XOR stuck-at-0, mode 2: outputs tied to zero
    assign gate_out = (mode == 2) ? 8'h00 : (mode == 1) ? (good & 8'hBF) : good;
    gate_selftest_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .gate_a_o(gate_a), .gate_b_o(gate_b), .gate_out_i(gate_out),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_mask_o(fail_mask), .fail_obs_o(fail_obs)
    );
    task automatic run(input int restart_at, output int done_edge, output int done_cnt,
                       output int seq_err);
        done_edge = -1;
        done_cnt  = 0;
        seq_err   = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (!busy) seq_err++;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if (e == restart_at - 1) start = 1'b1;
            if (e == restart_at) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (e % 4 == 2 && e < 16 && {gate_a, gate_b} != 2'(e / 4)) seq_err++;
            if ((e < 16) != busy) seq_err++;
        end
    endtask
    task automatic test_reset();
        n_chk++;
        if ({busy, done, pass, gate_a, gate_b, fail_mask, fail_obs} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b a=%b b=%b mask=%h obs=%h, want all 0",
                     busy, done, pass, gate_a, gate_b, fail_mask, fail_obs);
        end
    endtask
    task automatic test_good(input string name, input int restart_at);
        int de, dc, se;
        mode = 0;
        run(restart_at, de, dc, se);
        n_chk++;
        if (de !== 16) begin n_fail++; $display("FAIL %s_done_edge: got %0d want 16", name, de); end
        n_chk++;
        if (dc !== 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", name, dc); end
        n_chk++;
        if (se !== 0) begin n_fail++; $display("FAIL %s_sequence: got %0d errors want 0", name, se); end
        n_chk++;
        if ({pass, fail_mask, fail_obs} !== {1'b1, 4'h0, 8'h00}) begin
            n_fail++;
            $display("FAIL %s_result: got pass=%b mask=%h obs=%h want pass=1 mask=0 obs=00", name, pass, fail_mask, fail_obs);
        end
        n_chk++;
        if ({gate_a, gate_b} !== 2'b00) begin n_fail++; $display("FAIL %s_gates_idle: got %b%b want 00", name, gate_a, gate_b); end
    endtask
    task automatic test_fault(input string name, input int m, input logic [3:0] exp_mask,
                              input logic [7:0] exp_obs);
        int de, dc, se;
        mode = m;
        run(0, de, dc, se);
        n_chk++;
        if (de !== 16 || dc !== 1) begin n_fail++; $display("FAIL %s_done: got edge=%0d count=%0d want edge=16 count=1", name, de, dc); end
        n_chk++;
        if (pass !== 1'b0) begin n_fail++; $display("FAIL %s_pass: got %b want 0", name, pass); end
        n_chk++;
        if (fail_mask !== exp_mask) begin n_fail++; $display("FAIL %s_mask: got %h want %h", name, fail_mask, exp_mask); end
        n_chk++;
        if (fail_obs !== exp_obs) begin n_fail++; $display("FAIL %s_obs: got %h want %h", name, fail_obs, exp_obs); end
        mode = 0;
    endtask
    task automatic test_abort();
        int dc = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, gate_a, gate_b} !== 3'b110) begin n_fail++; $display("FAIL abort_pre: got busy=%b gates=%b%b want 1 10", busy, gate_a, gate_b); end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        n_chk++;
        if ({busy, done, gate_a, gate_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_post: got busy=%b done=%b gates=%b%b want 0 0 00", busy, done, gate_a, gate_b);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dc++;
        end
        n_chk++;
        if (dc !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", dc); end
    endtask
    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 34) start = 1'b0;
            if (done && d1 < 0) d1 = e;
            else if (done && d2 < 0) d2 = e;
        end
        n_chk++;
        if (d1 !== 16 || d2 !== 34) begin n_fail++; $display("FAIL back_to_back: got done at %0d,%0d want 16,34", d1, d2); end
        n_chk++;
        if (busy !== 1'b0 || pass !== 1'b1) begin n_fail++; $display("FAIL back_to_back_end: got busy=%b pass=%b want 0 1", busy, pass); end
    endtask
    task automatic test_reset_mid_run();
        int act = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, gate_a, gate_b} !== 3'b101) begin n_fail++; $display("FAIL rst_pre: got busy=%b gates=%b%b want 1 01", busy, gate_a, gate_b); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, pass, gate_a, gate_b, fail_mask, fail_obs} !== 17'd0) begin
            n_fail++;
            $display("FAIL rst_async: got busy=%b done=%b pass=%b gates=%b%b mask=%h obs=%h want all 0",
                     busy, done, pass, gate_a, gate_b, fail_mask, fail_obs);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (busy || done) act++;
        end
        n_chk++;
        if (act !== 0) begin n_fail++; $display("FAIL rst_idle: got %0d active cycles want 0", act); end
    endtask
    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_good("good", 0);
        test_fault("xor_sa0", 1, 4'b0110, 8'h1A);
        test_fault("zero", 2, 4'hF, 8'h00);
        test_abort();
        test_good("after_abort", 0);
        test_good("restart5", 5);
        test_back_to_back();
        test_reset_mid_run();
        test_good("after_reset", 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
